// File: rtl/trap_controller.sv
// M-mode trap/interrupt controller: prioritised interrupt/exception capture,
// vectored trap-address generation and a WFI sleep state driving the PC mux.
`timescale 1ns/1ps
module trap_controller #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     NUM_IRQ   = 16,
    parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               ILLEGAL_INSTR,
    input  logic               MISALIGNED_INSTR,
    input  logic               ECALL,
    input  logic               EBREAK,
    input  logic               MRET,
    input  logic               WFI,
    input  logic               E_IRQ,
    input  logic               T_IRQ,
    input  logic               S_IRQ,
    input  logic [NUM_IRQ-1:0] LOCAL_IRQ,
    input  logic               MIE,
    input  logic               MEIE,
    input  logic               MTIE,
    input  logic               MSIE,
    input  logic [NUM_IRQ-1:0] MLIE,
    input  logic               MEIP,
    input  logic               MTIP,
    input  logic               MSIP,
    input  logic [XLEN-3:0]    MTVEC_BASE,
    input  logic               MTVEC_MODE,
    output logic               I_OR_E,
    output logic [4:0]         CAUSE,
    output logic [XLEN-1:0]    TRAP_ADDR,
    output logic               SET_EPC,
    output logic               SET_CAUSE,
    output logic               MIE_CLEAR,
    output logic               MIE_SET,
    output logic               INSTRET_INC,
    output logic [1:0]         PC_SRC,
    output logic               STALL,
    output logic               SLEEPING
);

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_OPERATING  = 3'd1,
        ST_TRAP_TAKEN = 3'd2,
        ST_RETURN     = 3'd3,
        ST_WAIT       = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PC_BOOT      = 2'd0,
        PC_OPERATING = 2'd1,
        PC_TRAP      = 2'd2,
        PC_EPC       = 2'd3
    } pc_src_e;

    if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_num_irq_range
        $error("trap_controller: NUM_IRQ must be within 1..16");
    end
    if (BOOT_ADDR[1:0] != 2'b00) begin : g_boot_addr_align
        $error("trap_controller: BOOT_ADDR must be word aligned");
    end

    state_e              state_q, state_d;
    logic [4:0]          cause_q, cause_d;
    logic                i_or_e_q, i_or_e_d;
    logic [XLEN-1:0]     trap_addr_q, trap_addr_d;

    logic                eip, sip, tip;
    logic [NUM_IRQ-1:0]  lip;
    logic                ip, exception, irq_take, take;
    logic                lip_hit;
    logic [4:0]          lip_cause;
    logic                sel_irq;
    logic [4:0]          sel_cause;
    logic                capture;
    logic [XLEN-1:0]     base_addr;
    pc_src_e             pc_src;

    assign eip       = MEIE & (E_IRQ | MEIP);
    assign sip       = MSIE & (S_IRQ | MSIP);
    assign tip       = MTIE & (T_IRQ | MTIP);
    assign lip       = MLIE & LOCAL_IRQ;
    assign ip        = eip | sip | tip | (|lip);
    assign exception = ILLEGAL_INSTR | MISALIGNED_INSTR | ECALL | EBREAK;
    assign irq_take  = MIE & ip;
    assign take      = irq_take | exception;

    // Ascending scan so the highest pending local line wins.
    always_comb begin
        lip_hit   = 1'b0;
        lip_cause = 5'd16;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (lip[i]) begin
                lip_hit   = 1'b1;
                lip_cause = 5'(16 + i);
            end
        end
    end

    always_comb begin
        sel_irq   = 1'b1;
        sel_cause = '0;
        if (MIE & eip) begin
            sel_cause = 5'd11;
        end else if (MIE & sip) begin
            sel_cause = 5'd3;
        end else if (MIE & tip) begin
            sel_cause = 5'd7;
        end else if (MIE & lip_hit) begin
            sel_cause = lip_cause;
        end else begin
            sel_irq = 1'b0;
            if (ILLEGAL_INSTR) begin
                sel_cause = 5'd2;
            end else if (MISALIGNED_INSTR) begin
                sel_cause = 5'd0;
            end else if (ECALL) begin
                sel_cause = 5'd11;
            end else if (EBREAK) begin
                sel_cause = 5'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_src      = PC_BOOT;
        SET_EPC     = 1'b0;
        SET_CAUSE   = 1'b0;
        MIE_CLEAR   = 1'b0;
        MIE_SET     = 1'b0;
        INSTRET_INC = 1'b0;
        STALL       = 1'b0;
        SLEEPING    = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_OPERATING;
            end
            ST_OPERATING: begin
                pc_src      = PC_OPERATING;
                INSTRET_INC = 1'b1;
                if (take) begin
                    state_d = ST_TRAP_TAKEN;
                end else if (MRET) begin
                    state_d = ST_RETURN;
                end else if (WFI) begin
                    state_d = ST_WAIT;
                end
            end
            ST_TRAP_TAKEN: begin
                state_d   = ST_OPERATING;
                pc_src    = PC_TRAP;
                STALL     = 1'b1;
                SET_EPC   = 1'b1;
                SET_CAUSE = 1'b1;
                MIE_CLEAR = 1'b1;
            end
            ST_RETURN: begin
                state_d = ST_OPERATING;
                pc_src  = PC_EPC;
                STALL   = 1'b1;
                MIE_SET = 1'b1;
            end
            ST_WAIT: begin
                pc_src   = PC_OPERATING;
                STALL    = 1'b1;
                SLEEPING = 1'b1;
                if (irq_take) begin
                    state_d = ST_TRAP_TAKEN;
                end else if (ip) begin
                    state_d = ST_OPERATING;
                end
            end
            default: begin
                state_d = ST_OPERATING;
            end
        endcase
    end

    // Only OPERATING and WAIT can enter TRAP_TAKEN; in WAIT the entry is
    // always interrupt-driven, so the priority mux already picks an IRQ.
    assign capture   = ((state_q == ST_OPERATING) || (state_q == ST_WAIT)) &&
                       (state_d == ST_TRAP_TAKEN);
    assign base_addr = {MTVEC_BASE, 2'b00};

    always_comb begin
        cause_d     = cause_q;
        i_or_e_d    = i_or_e_q;
        trap_addr_d = trap_addr_q;
        if (capture) begin
            cause_d  = sel_cause;
            i_or_e_d = sel_irq;
            if (sel_irq && MTVEC_MODE) begin
                trap_addr_d = base_addr + XLEN'({sel_cause, 2'b00});
            end else begin
                trap_addr_d = base_addr;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_RESET;
            cause_q     <= '0;
            i_or_e_q    <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            i_or_e_q    <= i_or_e_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign PC_SRC    = pc_src;
    assign CAUSE     = cause_q;
    assign I_OR_E    = i_or_e_q;
    assign TRAP_ADDR = trap_addr_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed-vector bench for trap_controller with hand-computed expectations.
`timescale 1ns/1ps
module tb_trap_controller;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_IRQ = 16;

    localparam logic [1:0] PC_BOOT = 2'd0;
    localparam logic [1:0] PC_OPER = 2'd1;
    localparam logic [1:0] PC_TRAP = 2'd2;
    localparam logic [1:0] PC_EPC  = 2'd3;

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic               ILLEGAL_INSTR, MISALIGNED_INSTR, ECALL, EBREAK, MRET, WFI;
    logic               E_IRQ, T_IRQ, S_IRQ;
    logic [NUM_IRQ-1:0] LOCAL_IRQ;
    logic               MIE, MEIE, MTIE, MSIE;
    logic [NUM_IRQ-1:0] MLIE;
    logic               MEIP, MTIP, MSIP;
    logic [XLEN-3:0]    MTVEC_BASE;
    logic               MTVEC_MODE;
    logic               I_OR_E;
    logic [4:0]         CAUSE;
    logic [XLEN-1:0]    TRAP_ADDR;
    logic               SET_EPC, SET_CAUSE, MIE_CLEAR, MIE_SET, INSTRET_INC;
    logic [1:0]         PC_SRC;
    logic               STALL, SLEEPING;

    int n_checks = 0;
    int n_errors = 0;

    trap_controller #(
        .XLEN      (XLEN),
        .NUM_IRQ   (NUM_IRQ),
        .BOOT_ADDR (32'h0000_0000)
    ) dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .ILLEGAL_INSTR    (ILLEGAL_INSTR),
        .MISALIGNED_INSTR (MISALIGNED_INSTR),
        .ECALL            (ECALL),
        .EBREAK           (EBREAK),
        .MRET             (MRET),
        .WFI              (WFI),
        .E_IRQ            (E_IRQ),
        .T_IRQ            (T_IRQ),
        .S_IRQ            (S_IRQ),
        .LOCAL_IRQ        (LOCAL_IRQ),
        .MIE              (MIE),
        .MEIE             (MEIE),
        .MTIE             (MTIE),
        .MSIE             (MSIE),
        .MLIE             (MLIE),
        .MEIP             (MEIP),
        .MTIP             (MTIP),
        .MSIP             (MSIP),
        .MTVEC_BASE       (MTVEC_BASE),
        .MTVEC_MODE       (MTVEC_MODE),
        .I_OR_E           (I_OR_E),
        .CAUSE            (CAUSE),
        .TRAP_ADDR        (TRAP_ADDR),
        .SET_EPC          (SET_EPC),
        .SET_CAUSE        (SET_CAUSE),
        .MIE_CLEAR        (MIE_CLEAR),
        .MIE_SET          (MIE_SET),
        .INSTRET_INC      (INSTRET_INC),
        .PC_SRC           (PC_SRC),
        .STALL            (STALL),
        .SLEEPING         (SLEEPING)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ILLEGAL_INSTR = 0; MISALIGNED_INSTR = 0; ECALL = 0; EBREAK = 0;
        MRET = 0; WFI = 0; E_IRQ = 0; T_IRQ = 0; S_IRQ = 0;
        LOCAL_IRQ = '0; MIE = 0; MEIE = 0; MTIE = 0; MSIE = 0;
        MLIE = '0; MEIP = 0; MTIP = 0; MSIP = 0;
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    // Trap-taken cycle: PC mux, strobes and captured cause/address.
    task automatic check_trap(input string tag, input logic [4:0] cause,
                              input logic irq, input logic [31:0] addr);
        check({tag, ".pc"},    32'(PC_SRC), 32'(PC_TRAP));
        check({tag, ".cause"}, 32'(CAUSE), 32'(cause));
        check({tag, ".irq"},   32'(I_OR_E), 32'(irq));
        check({tag, ".addr"},  TRAP_ADDR, addr);
        check({tag, ".strb"},  {28'd0, SET_EPC, SET_CAUSE, MIE_CLEAR, STALL}, 32'hF);
    endtask

    initial begin
        clear_inputs();
        MTVEC_BASE = '0;
        MTVEC_MODE = 0;
        RESET_N    = 0;
        repeat (2) step();
        check("rst.pc", 32'(PC_SRC), 32'(PC_BOOT));
        check("rst.cause", 32'(CAUSE), 32'd0);
        check("rst.addr", TRAP_ADDR, 32'd0);
        check("rst.strb", {26'd0, SET_EPC, SET_CAUSE, MIE_CLEAR, MIE_SET, INSTRET_INC, STALL}, 32'd0);

        RESET_N = 1;
        #1 check("rel.boot", 32'(PC_SRC), 32'(PC_BOOT));
        step();
        check("rel.oper", 32'(PC_SRC), 32'(PC_OPER));
        check("rel.instret", 32'(INSTRET_INC), 32'd1);

        // External IRQ pre-empts a simultaneous illegal instruction.
        MTVEC_BASE = 30'h800; MTVEC_MODE = 1;
        MIE = 1; MEIE = 1; E_IRQ = 1; ILLEGAL_INSTR = 1;
        step();
        check_trap("ext", 5'd11, 1'b1, 32'h202C);
        clear_inputs();
        step();
        check("ext.back", 32'(PC_SRC), 32'(PC_OPER));

        // Local lines 1 and 3 pending: line 3 wins.
        MTVEC_BASE = 30'h40;
        LOCAL_IRQ = 16'h000A; MLIE = 16'h00FF; MIE = 1;
        step();
        check_trap("lvec", 5'd19, 1'b1, 32'h14C);
        clear_inputs();
        step();
        MTVEC_MODE = 0;
        LOCAL_IRQ = 16'h000A; MLIE = 16'h00FF; MIE = 1;
        step();
        check_trap("ldir", 5'd19, 1'b1, 32'h100);
        clear_inputs();
        step();

        // WFI, wake with MIE=0: no trap, cause held.
        WFI = 1;
        step();
        check("wfi.pc", 32'(PC_SRC), 32'(PC_OPER));
        check("wfi.flags", {29'd0, STALL, SLEEPING, INSTRET_INC}, 32'b110);
        WFI = 0; ECALL = 1;
        step();
        check("wfi.ignore_ecall", 32'(SLEEPING), 32'd1);
        ECALL = 0;
        repeat (3) step();
        check("wfi.still", 32'(SLEEPING), 32'd1);
        MTIE = 1; T_IRQ = 1;
        step();
        check("wake.pc", 32'(PC_SRC), 32'(PC_OPER));
        check("wake.flags", {28'd0, SLEEPING, STALL, SET_EPC, INSTRET_INC}, 32'b0001);
        check("wake.cause_held", 32'(CAUSE), 32'd19);
        clear_inputs();
        step();

        // WFI, wake with MIE=1: timer trap.
        WFI = 1;
        step();
        check("wfi2.sleep", 32'(SLEEPING), 32'd1);
        WFI = 0;
        step();
        MTIE = 1; T_IRQ = 1; MIE = 1;
        step();
        check_trap("wake_trap", 5'd7, 1'b1, 32'h100);
        clear_inputs();
        step();

        // MRET alone, then MRET pre-empted by software interrupt.
        MRET = 1;
        step();
        check("mret.pc", 32'(PC_SRC), 32'(PC_EPC));
        check("mret.flags", {28'd0, MIE_SET, STALL, SET_EPC, MIE_CLEAR}, 32'b1100);
        clear_inputs();
        step();
        check("mret.back", 32'(PC_SRC), 32'(PC_OPER));
        MTVEC_MODE = 1;
        MRET = 1; MIE = 1; MSIP = 1; MSIE = 1;
        step();
        check_trap("mret_sw", 5'd3, 1'b1, 32'h10C);
        clear_inputs();
        step();

        // Exceptions are never vectored; priority among them.
        ECALL = 1;
        step();
        check_trap("ecall", 5'd11, 1'b0, 32'h100);
        clear_inputs();
        step();
        MISALIGNED_INSTR = 1; ECALL = 1; EBREAK = 1;
        step();
        check_trap("misal", 5'd0, 1'b0, 32'h100);
        clear_inputs();
        step();
        ILLEGAL_INSTR = 1; MISALIGNED_INSTR = 1;
        step();
        check_trap("illegal", 5'd2, 1'b0, 32'h100);
        clear_inputs();
        step();
        EBREAK = 1;
        step();
        check_trap("ebreak", 5'd3, 1'b0, 32'h100);
        clear_inputs();
        step();

        // Software beats timer; pending without MIE but with exception is an exception.
        S_IRQ = 1; MSIE = 1; T_IRQ = 1; MTIE = 1; MIE = 1;
        step();
        check_trap("sw_tmr", 5'd3, 1'b1, 32'h10C);
        clear_inputs();
        step();
        E_IRQ = 1; MEIE = 1; ECALL = 1;
        step();
        check_trap("nomie", 5'd11, 1'b0, 32'h100);
        clear_inputs();
        step();

        // Vectored address wraps modulo 2^32.
        MTVEC_BASE = 30'h3FFF_FFFC;
        LOCAL_IRQ = 16'h0001; MLIE = 16'hFFFF; MIE = 1;
        step();
        check_trap("wrap", 5'd16, 1'b1, 32'h0000_0030);
        clear_inputs();
        step();

        // Reset asserted during TRAP_TAKEN takes effect immediately.
        ECALL = 1;
        step();
        check("mid.pc", 32'(PC_SRC), 32'(PC_TRAP));
        clear_inputs();
        #1 RESET_N = 0;
        #1;
        check("mid.rst_pc", 32'(PC_SRC), 32'(PC_BOOT));
        check("mid.rst_cause", 32'(CAUSE), 32'd0);
        check("mid.rst_addr", TRAP_ADDR, 32'd0);
        check("mid.rst_strb", {28'd0, SET_EPC, SET_CAUSE, MIE_CLEAR, STALL}, 32'd0);
        step();
        RESET_N = 1;
        #1 check("mid.rel_boot", 32'(PC_SRC), 32'(PC_BOOT));
        step();
        check("mid.rel_oper", 32'(PC_SRC), 32'(PC_OPER));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Parametrised M-mode trap/interrupt controller; next generation of the core's machine-mode control FSM.
- Adds NUM_IRQ prioritised local interrupt lines, vectored trap-address generation and a WFI sleep state.
- Sits between the decoder/CSR file and the PC mux.
- Drives PC source, stage-2 stall, CSR update strobes, cause code and trap target address.

Parameters:
- XLEN, 32, datapath/address width.
- NUM_IRQ, 16, number of local interrupt lines. Legal range 1..16. Local line i uses cause code 16+i.
- BOOT_ADDR, 32'h0000_0000, PC value presented during STATE_RESET.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- ILLEGAL_INSTR  in  1  illegal instruction from control unit.
- MISALIGNED_INSTR  in  1  misaligned fetch from stage 1.
- ECALL, EBREAK, MRET, WFI  in  1 each  decoded system instructions, mutually exclusive.
- E_IRQ, T_IRQ, S_IRQ  in  1 each  external, timer and software interrupt requests, level.
- LOCAL_IRQ  in  NUM_IRQ  local interrupt requests, level.
- MIE  in  1  mstatus.MIE.
- MEIE, MTIE, MSIE  in  1 each  standard interrupt enables.
- MLIE  in  NUM_IRQ  local interrupt enables (mie[16+i]).
- MEIP, MTIP, MSIP  in  1 each  CSR pending bits.
- MTVEC_BASE  in  XLEN-2  mtvec[XLEN-1:2].
- MTVEC_MODE  in  1  0 = direct, 1 = vectored.
- I_OR_E  out  1  registered; 1 = interrupt, 0 = exception.
- CAUSE  out  5  registered cause code.
- TRAP_ADDR  out  XLEN  registered trap target.
- SET_EPC, SET_CAUSE, MIE_CLEAR, MIE_SET, INSTRET_INC  out  1 each  CSR strobes.
- PC_SRC  out  2  PC mux select, using the shared BOOT/OPERATING/TRAP/EPC codes.
- STALL  out  1  stage-2 stall.
- SLEEPING  out  1  high while in STATE_WAIT.

Behaviour:
- Pending terms:
  - eip = MEIE&(E_IRQ|MEIP)
  - sip = MSIE&(S_IRQ|MSIP)
  - tip = MTIE&(T_IRQ|MTIP)
  - lip = MLIE&LOCAL_IRQ
  - ip = eip|sip|tip|(|lip)
  - exception = ILLEGAL_INSTR|MISALIGNED_INSTR|ECALL|EBREAK
- Take condition: take = (MIE&ip)|exception.
- States:
  - RESET -> OPERATING unconditionally.
  - OPERATING -> TRAP_TAKEN if take; else RETURN if MRET; else WAIT if WFI; else OPERATING.
  - TRAP_TAKEN -> OPERATING.
  - RETURN -> OPERATING.
  - WAIT -> TRAP_TAKEN if MIE&ip; else OPERATING if ip (wake without trap, MIE=0); else WAIT. Decoded-instruction inputs are ignored in WAIT.
  - Illegal state encoding -> OPERATING.
- Outputs per state:
  - RESET: PC_SRC=BOOT, all strobes 0, STALL=0.
  - OPERATING: PC_SRC=OPERATING, INSTRET_INC=1, others 0.
  - TRAP_TAKEN: PC_SRC=TRAP, STALL=1, SET_EPC=1, SET_CAUSE=1, MIE_CLEAR=1.
  - RETURN: PC_SRC=EPC, STALL=1, MIE_SET=1.
  - WAIT: PC_SRC=OPERATING, STALL=1, SLEEPING=1, INSTRET_INC=0.
- Cause capture: on the edge leaving OPERATING or WAIT toward TRAP_TAKEN, CAUSE/I_OR_E load the highest-priority source. Priority order:
  1. MIE&eip -> 11, I=1
  2. MIE&sip -> 3, I=1
  3. MIE&tip -> 7, I=1
  4. MIE&lip[j], j = highest set index -> 16+j, I=1
  5. ILLEGAL_INSTR -> 2
  6. MISALIGNED_INSTR -> 0
  7. ECALL -> 11
  8. EBREAK -> 3
- CAUSE/I_OR_E otherwise hold.
- TRAP_ADDR loads on the same edge as CAUSE:
  - Interrupt with MTVEC_MODE=1: {MTVEC_BASE,2'b00} + 4*cause, modulo 2^XLEN (wrap, no saturation).
  - Otherwise: {MTVEC_BASE,2'b00}.
- Trap-entry latency: the trap is visible on PC_SRC/strobes exactly 1 cycle after the triggering cycle.
- Simultaneous events: an interrupt pre-empts an exception in the same cycle. take pre-empts MRET and WFI.
- Reset: RESET_N low at any time (including mid-trap) forces RESET state immediately.
  - CAUSE=0, I_OR_E=0, TRAP_ADDR=0.
  - Outputs take RESET-state values.
  - The first edge after RESET_N rises enters OPERATING.

Test Plan:
- Reset, then release -> PC_SRC BOOT for 1 cycle, then OPERATING; CAUSE=0, TRAP_ADDR=0. Repeat with reset asserted during TRAP_TAKEN -> immediate RESET.
- MIE=1, MEIE=1, E_IRQ=1 with ILLEGAL_INSTR=1 in the same cycle, MTVEC_BASE=0x2000>>2, MODE=1 -> next cycle TRAP_TAKEN, CAUSE=11, I_OR_E=1, TRAP_ADDR=0x202C, SET_EPC=SET_CAUSE=MIE_CLEAR=1.
- LOCAL_IRQ=0x0A, MLIE=0xFF, MIE=1, MODE=1, base 0x100 -> CAUSE=19, TRAP_ADDR=0x14C. Repeat with MODE=0 -> TRAP_ADDR=0x100.
- WFI with no pending interrupt -> WAIT, STALL=1, SLEEPING=1, INSTRET_INC=0. After 5 cycles assert T_IRQ with MTIE=1:
  - MIE=0 -> OPERATING, no trap.
  - MIE=1 -> TRAP_TAKEN, CAUSE=7.
- MRET -> RETURN for 1 cycle (PC_SRC=EPC, MIE_SET=1, STALL=1), then OPERATING. MRET with MIE=1 and MSIP=1, MSIE=1 -> TRAP_TAKEN, CAUSE=3, I_OR_E=1.
- Base 0xFFFF_FFF0 (MTVEC_BASE all ones except low bits), MODE=1, local line 0 -> TRAP_ADDR wraps to 0x0000_0030.
